// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB-75 row driver.
package hub75_pkg;
  typedef enum logic [2:0] {kInit, kWait, kShift, kFlush, kLatch, kBlank, kDisplay} state_e;

  localparam int kFlushCycles = 2;
  localparam int kMaxDataW    = 6 * 32;

  // Colour bit of one field at a given plane; data is zero-extended by the caller.
  function automatic logic field_bit(input logic [kMaxDataW-1:0] data, input int cb,
                                     input int field, input int plane);
    logic [kMaxDataW-1:0] s;
    s = data >> (field * cb + plane);
    return s[0];
  endfunction
endpackage

// File: rtl/hub75_bcm_driver_timer.sv
// Display-period timer: loads period and on-time for a plane, then counts both down.
module hub75_plane_timer #(
  parameter int COLOR_BITS = 8,
  parameter int BASE_ON    = 1,
  parameter int PLANE_W    = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic               run,
  input  logic [PLANE_W-1:0] plane,
  input  logic [7:0]         bright,
  output logic               on_first,
  output logic               on_next,
  output logic               last
);
  localparam int PW = COLOR_BITS - 1 + $clog2(BASE_ON) + 1;

  logic [PW-1:0]   period, on_cnt, rem_q, on_q;
  logic [PW+7:0]   prod;

  always_comb begin
    period   = PW'(BASE_ON) << plane;
    // Full-width product so the >>8 sees every bit.
    prod     = {8'b0, period} * {{PW{1'b0}}, bright};
    on_cnt   = prod[PW+7:8];
    on_first = |on_cnt;
    on_next  = on_q > PW'(1);
    last     = (rem_q == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem_q <= '0;
      on_q  <= '0;
    end else if (load) begin
      rem_q <= period - 1'b1;
      on_q  <= on_cnt;
    end else if (run) begin
      if (rem_q != '0) rem_q <= rem_q - 1'b1;
      if (on_q != '0)  on_q  <= on_q - 1'b1;
    end
  end
endmodule

// File: rtl/hub75_bcm_driver.sv
// HUB-75 row driver: shifts one row pair per plane and shows it with binary-coded modulation.
module hub75_bcm_driver
  import hub75_pkg::*;
#(
  parameter int COLOR_BITS   = 8,
  parameter int PANEL_WIDTH  = 64,
  parameter int ROW_BITS     = 5,
  parameter int BASE_ON      = 1,
  parameter int BLANK_CYCLES = 2,
  localparam int X_BITS      = $clog2(PANEL_WIDTH)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [ROW_BITS-1:0]     y,
  input  logic                    start,
  input  logic [7:0]              brightness,
  output logic                    is_idle,
  output logic                    done,
  output logic [X_BITS:0]         read_address,
  input  logic [6*COLOR_BITS-1:0] read_data,
  output logic                    r1,
  output logic                    g1,
  output logic                    b1,
  output logic                    r2,
  output logic                    g2,
  output logic                    b2,
  output logic [ROW_BITS-1:0]     abcde,
  output logic                    hub_clk,
  output logic                    lat,
  output logic                    oe_n
);
  localparam int PLANE_W = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int CNT_W   = $clog2(BLANK_CYCLES + kFlushCycles + 1);

  state_e               state_q;
  logic [X_BITS-1:0]    x_q;
  logic [PLANE_W-1:0]   plane_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [ROW_BITS-1:0]  y_q, abcde_q;
  logic [7:0]           bright_q;
  logic [2:1]           vld_pipe_q;
  logic [5:0]           color_q, color_d;
  logic                 lat_q, oe_n_q, done_q, idle_q, shift_en_q;
  logic                 tmr_load, on_first, on_next, period_last;
  logic [kMaxDataW-1:0] rd_ext;

  assign rd_ext       = kMaxDataW'(read_data);
  assign read_address = {y_q[0], x_q};
  assign shift_en_q   = vld_pipe_q[2];
  assign hub_clk      = ~clock & shift_en_q;
  assign {b2, g2, r2, b1, g1, r1} = color_q;
  assign abcde   = abcde_q;
  assign lat     = lat_q;
  assign oe_n    = oe_n_q;
  assign done    = done_q;
  assign is_idle = idle_q;

  always_comb begin
    color_d = {field_bit(rd_ext, COLOR_BITS, 5, int'(plane_q)),
               field_bit(rd_ext, COLOR_BITS, 4, int'(plane_q)),
               field_bit(rd_ext, COLOR_BITS, 3, int'(plane_q)),
               field_bit(rd_ext, COLOR_BITS, 2, int'(plane_q)),
               field_bit(rd_ext, COLOR_BITS, 1, int'(plane_q)),
               field_bit(rd_ext, COLOR_BITS, 0, int'(plane_q))};
    tmr_load = 1'b0;
    if (state_q == kLatch && BLANK_CYCLES == 0) tmr_load = 1'b1;
    if (state_q == kBlank && cnt_q == CNT_W'(BLANK_CYCLES - 1)) tmr_load = 1'b1;
  end

  hub75_plane_timer #(
    .COLOR_BITS(COLOR_BITS), .BASE_ON(BASE_ON), .PLANE_W(PLANE_W)
  ) u_timer (
    .clock, .reset_n, .load(tmr_load), .run(state_q == kDisplay),
    .plane(plane_q), .bright(bright_q),
    .on_first, .on_next, .last(period_last)
  );

  // Pin data trails its address by RAM latency plus the colour register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      color_q    <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], state_q == kShift};
      if (vld_pipe_q[1]) color_q <= color_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= kInit;
      x_q      <= '0;
      plane_q  <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
      bright_q <= '0;
      abcde_q  <= '0;
      lat_q    <= 1'b0;
      oe_n_q   <= 1'b1;
      done_q   <= 1'b0;
      idle_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      lat_q  <= 1'b0;
      case (state_q)
        kInit: begin
          state_q <= kWait;
          idle_q  <= 1'b1;
        end
        kWait: if (start) begin
          y_q      <= y;
          bright_q <= brightness;
          plane_q  <= '0;
          x_q      <= '0;
          idle_q   <= 1'b0;
          state_q  <= kShift;
        end
        kShift: begin
          x_q <= x_q + 1'b1;
          if (&x_q) begin
            cnt_q   <= '0;
            state_q <= kFlush;
          end
        end
        kFlush: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(kFlushCycles - 1)) begin
            state_q <= kLatch;
            lat_q   <= 1'b1;
            abcde_q <= y_q;
          end
        end
        kLatch: begin
          cnt_q <= '0;
          if (BLANK_CYCLES == 0) begin
            state_q <= kDisplay;
            oe_n_q  <= ~on_first;
          end else begin
            state_q <= kBlank;
          end
        end
        kBlank: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_q <= kDisplay;
            oe_n_q  <= ~on_first;
          end
        end
        kDisplay: begin
          if (period_last) begin
            oe_n_q <= 1'b1;
            if (plane_q == PLANE_W'(COLOR_BITS - 1)) begin
              state_q <= kWait;
              done_q  <= 1'b1;
              idle_q  <= 1'b1;
            end else begin
              plane_q <= plane_q + 1'b1;
              state_q <= kShift;
            end
          end else begin
            oe_n_q <= ~on_next;
          end
        end
        default: state_q <= kInit;
      endcase
    end
  end
endmodule
